trng_osc_seq: RTL and testbench

// - Sequencer for a bank of free-running XOR/AND oscillator cells (trigger T, arm inputs I1/I2, output OSC).
// - Per random bit: reset the cells, arm them, release the trigger, then sample.
// - Sampled outputs are synchronized and XOR-folded into one bit; 32 bits are packed into a word.
// - The word is handed to the PicoRV32 peripheral side over a valid/ready handshake.

---
 rtl/trng_osc_seq.sv | 200 ++++++++++++++++++++
 tb/tb_trng_osc_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/trng_osc_seq.sv
// ============================================================================
// Module   : trng_osc_seq
// Purpose  : Sequencer for a bank of XOR/AND oscillator cells. For each random
//            bit it resets the cells, arms them, releases the trigger, then
//            samples the synchronized, XOR-folded cell outputs. 32 bits are
//            packed into a word offered over a valid/ready handshake.
// Config   : `define TRNG_HEALTH_EN to add a repetition-count health test on
//            the folded sample (sticky health_fail output).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trng_osc_seq #(
   parameter int N_OSC   = 4,
   parameter int RST_CYC = 4,
   parameter int ARM_CYC = 2,
   parameter int RUN_CYC = 64,
   parameter int REP_LIM = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             en,
   input  logic [N_OSC-1:0] osc_in,
   output logic             osc_t,
   output logic             osc_i1,
   output logic             osc_i2,
   output logic [31:0]      rnd_data,
   output logic             rnd_valid,
   input  logic             rnd_ready,
   output logic             busy,
   output logic             health_fail
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RST  = 3'd1;
   localparam logic [2:0] S_ARM  = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   // Phase counter reload values (counter runs down to 0 inclusive)
   localparam logic [15:0] C_RST_LOAD = 16'(RST_CYC - 1);
   localparam logic [15:0] C_ARM_LOAD = 16'(ARM_CYC - 1);
   localparam logic [15:0] C_RUN_LOAD = 16'(RUN_CYC - 1);

   logic [2:0]       state_q,   state_d;
   logic [15:0]      phase_q,   phase_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic             arm_sel_q, arm_sel_d;
   logic [31:0]      data_q,    data_d;
   logic [N_OSC-1:0] sync1_q,   sync2_q;
   logic             samp_bit;
   logic             sample_now;
   logic             health_trip;
   logic             health_q;

   // Two-stage synchronizer on the asynchronous oscillator outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= osc_in;
         sync2_q <= sync1_q;
      end
   end

   assign samp_bit   = ^sync2_q;
   // Last clock of the RUN phase with generation still enabled
   assign sample_now = (state_q == S_RUN) && en && (phase_q == 16'd0);

`ifdef TRNG_HEALTH_EN
   logic [7:0] rep_q;
   logic [7:0] rep_next;
   logic       last_q;

   // Run length of identical samples including the current one, saturating
   always_comb begin
      rep_next = 8'd1;
      if ((samp_bit == last_q) && (rep_q != 8'd0)) begin
         rep_next = (rep_q == 8'hFF) ? 8'hFF : rep_q + 8'd1;
      end
   end

   assign health_trip = (rep_next >= 8'(REP_LIM));

   // Repetition-count state and sticky failure flag (cleared by en=0 in IDLE)
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rep_q    <= 8'd0;
         last_q   <= 1'b0;
         health_q <= 1'b0;
      end else if ((state_q == S_IDLE) && !en) begin
         rep_q    <= 8'd0;
         last_q   <= 1'b0;
         health_q <= 1'b0;
      end else if (sample_now) begin
         rep_q  <= rep_next;
         last_q <= samp_bit;
         if (health_trip) begin
            health_q <= 1'b1;
         end
      end
   end
`else
   assign health_trip = 1'b0;
   assign health_q    = 1'b0;
`endif

   // Next-state logic for the sequencer, bit counter and shift register
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_cnt_d = bit_cnt_q;
      arm_sel_d = arm_sel_q;
      data_d    = data_q;
      case (state_q)
         S_IDLE: begin
            if (en && !health_q) begin
               state_d = S_RST;
               phase_d = C_RST_LOAD;
            end
         end
         S_RST, S_ARM, S_RUN: begin
            if (!en) begin
               // Abandon the partial word
               state_d   = S_IDLE;
               phase_d   = 16'd0;
               bit_cnt_d = 5'd0;
               data_d    = 32'd0;
            end else if (phase_q != 16'd0) begin
               phase_d = phase_q - 16'd1;
            end else if (state_q == S_RST) begin
               state_d = S_ARM;
               phase_d = C_ARM_LOAD;
            end else if (state_q == S_ARM) begin
               state_d = S_RUN;
               phase_d = C_RUN_LOAD;
            end else begin
               data_d    = {data_q[30:0], samp_bit};
               bit_cnt_d = bit_cnt_q + 5'd1;
               arm_sel_d = ~arm_sel_q;
               if (health_trip) begin
                  state_d   = S_IDLE;
                  phase_d   = 16'd0;
                  bit_cnt_d = 5'd0;
                  data_d    = 32'd0;
               end else if (bit_cnt_q == 5'd31) begin
                  state_d = S_HOLD;
               end else begin
                  state_d = S_RST;
                  phase_d = C_RST_LOAD;
               end
            end
         end
         S_HOLD: begin
            if (rnd_ready) begin
               bit_cnt_d = 5'd0;
               if (en && !health_q) begin
                  state_d = S_RST;
                  phase_d = C_RST_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sequencer state registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         phase_q   <= 16'd0;
         bit_cnt_q <= 5'd0;
         arm_sel_q <= 1'b0;
         data_q    <= 32'd0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_cnt_q <= bit_cnt_d;
         arm_sel_q <= arm_sel_d;
         data_q    <= data_d;
      end
   end

   // Cell controls decode straight from the registered state (glitch-free)
   assign osc_t       = (state_q == S_RUN);
   assign osc_i1      = ((state_q == S_ARM) || (state_q == S_RUN)) && !arm_sel_q;
   assign osc_i2      = ((state_q == S_ARM) || (state_q == S_RUN)) &&  arm_sel_q;
   assign rnd_data    = data_q;
   assign rnd_valid   = (state_q == S_HOLD);
   assign busy        = (state_q != S_IDLE);
   assign health_fail = health_q;

endmodule

`default_nettype wire

// File: tb/tb_trng_osc_seq.sv
// ============================================================================
// Module   : tb_trng_osc_seq
// Purpose  : Self-checking bench for trng_osc_seq (RST=4, ARM=2, RUN=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trng_osc_seq;

   logic        clk;
   logic        resetn;
   logic        en;
   logic [3:0]  osc_in;
   logic        osc_t;
   logic        osc_i1;
   logic        osc_i2;
   logic [31:0] rnd_data;
   logic        rnd_valid;
   logic        rnd_ready;
   logic        busy;
   logic        health_fail;

   int n_tests;
   int n_fail;

   trng_osc_seq #(
      .N_OSC  (4),
      .RST_CYC(4),
      .ARM_CYC(2),
      .RUN_CYC(8),
      .REP_LIM(16)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .en         (en),
      .osc_in     (osc_in),
      .osc_t      (osc_t),
      .osc_i1     (osc_i1),
      .osc_i2     (osc_i2),
      .rnd_data   (rnd_data),
      .rnd_valid  (rnd_valid),
      .rnd_ready  (rnd_ready),
      .busy       (busy),
      .health_fail(health_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-cycle vector: inputs applied, expected {t,i1,i2,busy,valid} after the edge
   typedef struct {
      logic       en;
      logic [3:0] osc;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs[21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [4:0] ctl();
      return {osc_t, osc_i1, osc_i2, busy, rnd_valid};
   endfunction

   // Run until rnd_valid, counting edges; optionally drop osc_in to 0 after edge 15
   task automatic wait_valid(input bit drop15, output int cnt);
      cnt = 0;
      for (int k = 1; k <= 600; k++) begin
         tick();
         cnt = k;
         if (drop15 && k == 15) osc_in = 4'b0000;
         if (rnd_valid) break;
      end
      if (!rnd_valid) cnt = -1;
   endtask

   initial begin
      int cnt;
      n_tests = 0;
      n_fail  = 0;

      for (int i = 0; i < 21; i++) begin
         vecs[i].en  = 1'b1;
         vecs[i].osc = (i % 2 == 0) ? 4'b0101 : 4'b1011;
         if (i < 4)       vecs[i].exp = 5'b00010;
         else if (i < 6)  vecs[i].exp = 5'b01010;
         else if (i < 14) vecs[i].exp = 5'b11010;
         else if (i < 18) vecs[i].exp = 5'b00010;
         else if (i < 20) vecs[i].exp = 5'b00110;
         else             vecs[i].exp = 5'b10110;
      end

      resetn    = 1'b0;
      en        = 1'b0;
      osc_in    = 4'b0000;
      rnd_ready = 1'b0;
      repeat (3) tick();
      check("reset_ctl", {26'd0, ctl(), health_fail}, 32'd0);
      check("reset_data", rnd_data, 32'd0);
      resetn = 1'b1;
      tick();

      // Phase sequence of the first two bits
      for (int i = 0; i < 21; i++) begin
         en     = vecs[i].en;
         osc_in = vecs[i].osc;
         tick();
         check($sformatf("phase_vec%0d", i), {27'd0, ctl()}, {27'd0, vecs[i].exp});
      end

      // Reset asserted in the middle of RUN
      resetn = 1'b0;
      en     = 1'b0;
      tick();
      check("reset_mid_run", {26'd0, ctl(), health_fail}, 32'd0);
      resetn = 1'b1;
      tick();

`ifdef TRNG_HEALTH_EN
      // Constant zero input trips the repetition test on sample 16
      osc_in = 4'b0000;
      en     = 1'b1;
      cnt    = -1;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (k == 224) check("health_before", {31'd0, health_fail}, 32'd0);
         if (rnd_valid) begin
            check("health_no_valid", 32'd1, 32'd0);
            break;
         end
         if (health_fail) begin
            cnt = k;
            break;
         end
      end
      check("health_trip_cycle", cnt, 225);
      check("health_idle", {27'd0, ctl()}, 32'd0);
      repeat (5) tick();
      check("health_sticky", {26'd0, ctl(), health_fail}, 32'd1);
      en = 1'b0;
      tick();
      check("health_clear", {31'd0, health_fail}, 32'd0);
`else
      // All-ones word held until accepted
      osc_in = 4'b0001;
      en     = 1'b1;
      wait_valid(1'b0, cnt);
      check("ones_latency", cnt, 449);
      check("ones_data", rnd_data, 32'hFFFF_FFFF);
      repeat (4) tick();
      check("ones_hold_valid", {31'd0, rnd_valid}, 32'd1);
      check("ones_hold_data", rnd_data, 32'hFFFF_FFFF);
      rnd_ready = 1'b1;
      tick();
      rnd_ready = 1'b0;
      check("xfer_new_rst", {27'd0, ctl()}, {27'd0, 5'b00010});

      // Drop en while bit 5 is armed (bit 5 arms with I2)
      repeat (74) tick();
      check("bit5_arm", {29'd0, osc_t, osc_i1, osc_i2}, 32'd1);
      en = 1'b0;
      tick();
      check("abort_idle", {27'd0, ctl()}, 32'd0);

      // New word restarts from bit 0; first sampled bit lands in bit 31
      osc_in = 4'b0001;
      en     = 1'b1;
      wait_valid(1'b1, cnt);
      check("order_latency", cnt, 449);
      check("order_data", rnd_data, 32'h8000_0000);
      en        = 1'b0;
      rnd_ready = 1'b1;
      tick();
      rnd_ready = 1'b0;
      check("xfer_to_idle", {27'd0, ctl()}, 32'd0);

      // All-zero word, no health test present
      osc_in = 4'b0000;
      en     = 1'b1;
      wait_valid(1'b0, cnt);
      check("zero_latency", cnt, 449);
      check("zero_data", rnd_data, 32'h0000_0000);
      check("zero_health", {31'd0, health_fail}, 32'd0);
      en        = 1'b0;
      rnd_ready = 1'b1;
      tick();
      rnd_ready = 1'b0;
      check("zero_xfer_idle", {27'd0, ctl()}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
